// File: rtl/sync_rx_pkg.sv
// Shared types and defaults for the sync pulse receiver.
// Holds the state encoding and default counter / pulse-width parameters.
package sync_rx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SEARCH  = 2'd1,
      ST_ACQUIRE = 2'd2,
      ST_LOCKED  = 2'd3
   } state_e;

   localparam int C_PERIOD_W_DEF  = 16;
   localparam int C_MIN_WIDTH_DEF = 2;

endpackage

// File: rtl/sync_rx_if.sv
// Control/status bundle of the sync pulse receiver.
// Sync inputs, enable, clear, lock settings in; strobe, lock, stats out.
interface sync_rx_if #(
   parameter int W = 16
);
   logic         i_SyncRe_p;
   logic         i_SyncFe_p;
   logic         i_Enable_p;
   logic         i_ClearStats_p;
   logic [15:0]  iv16_ExpectedPeriod_p;
   logic [3:0]   iv4_Tolerance_p;
   logic [3:0]   iv4_LockCount_p;
   logic         o_SyncOut_p;
   logic         o_Locked_p;
   logic [W-1:0] ov16_MeasuredPeriod_p;
   logic [W-1:0] ov16_ErrorCount_p;
   logic         o_PhaseFe_p;
   logic [1:0]   ov2_State_p;

   modport master (
      output i_SyncRe_p, i_SyncFe_p, i_Enable_p, i_ClearStats_p,
      output iv16_ExpectedPeriod_p, iv4_Tolerance_p, iv4_LockCount_p,
      input  o_SyncOut_p, o_Locked_p, ov16_MeasuredPeriod_p,
      input  ov16_ErrorCount_p, o_PhaseFe_p, ov2_State_p
   );

   modport slave (
      input  i_SyncRe_p, i_SyncFe_p, i_Enable_p, i_ClearStats_p,
      input  iv16_ExpectedPeriod_p, iv4_Tolerance_p, iv4_LockCount_p,
      output o_SyncOut_p, o_Locked_p, ov16_MeasuredPeriod_p,
      output ov16_ErrorCount_p, o_PhaseFe_p, ov2_State_p
   );
endinterface

// File: rtl/sync_pulse_receiver_edge.sv
// Rising-edge detect, high-width (runt) measurement and phase flag.
// Ports: clk/rst, sync re/fe samples in; edge, runt strobes, phase out.
module sync_edge_detect #(
   parameter int C_MIN_WIDTH = 2
) (
   input  logic i_Clk_p,
   input  logic i_Rst_p,
   input  logic i_SyncRe_p,
   input  logic i_SyncFe_p,
   output logic o_Edge_p,
   output logic o_Runt_p,
   output logic o_Phase_p
);
   localparam int HW = $clog2(C_MIN_WIDTH + 2);
   localparam logic [HW-1:0] C_MAX = HW'(C_MIN_WIDTH);

   logic          re_q;
   logic          fe_q;
   logic [HW-1:0] hcnt_q;
   logic [HW-1:0] hcnt_d;

   // hcnt_q holds the number of high cycles seen so far; on the
   // falling cycle it is the completed pulse width.
   always_comb begin
      o_Edge_p  = i_SyncRe_p && !re_q;
      o_Runt_p  = !i_SyncRe_p && re_q && (hcnt_q < C_MAX);
      o_Phase_p = fe_q;
      hcnt_d    = hcnt_q;
      if (o_Edge_p) begin
         hcnt_d = HW'(1);
      end else if (i_SyncRe_p && (hcnt_q < C_MAX)) begin
         hcnt_d = hcnt_q + HW'(1);
      end
   end

   always_ff @(posedge i_Clk_p) begin
      if (i_Rst_p) begin
         re_q   <= 1'b0;
         fe_q   <= 1'b0;
         hcnt_q <= '0;
      end else begin
         re_q   <= i_SyncRe_p;
         fe_q   <= i_SyncFe_p;
         hcnt_q <= hcnt_d;
      end
   end
endmodule

// File: rtl/sync_pulse_receiver.sv
// Sync pulse receiver: period counter, tolerance check, lock FSM, stats.
// Ports: i_Clk_p, i_Rst_p (sync, active high), bus (sync_rx_if.slave).
module sync_pulse_receiver
   import sync_rx_pkg::*;
#(
   parameter int C_MIN_WIDTH = C_MIN_WIDTH_DEF,
   parameter int C_PERIOD_W  = C_PERIOD_W_DEF
) (
   input logic      i_Clk_p,
   input logic      i_Rst_p,
   sync_rx_if.slave bus
);
   localparam int CW = ((C_PERIOD_W > 16) ? C_PERIOD_W : 16) + 1;

   state_e                state_q, state_d;
   logic [3:0]            good_q, good_d;
   logic [C_PERIOD_W-1:0] cnt_q, cnt_d;
   logic [C_PERIOD_W-1:0] meas_q, meas_d;
   logic [C_PERIOD_W-1:0] err_q, err_d;
   logic                  phase_q, phase_d;
   logic                  strobe_q, strobe_d;

   logic          edge_w, runt_w, phase_w;
   logic          acc, good, miss, pred, in_lock, lock_err;
   logic [CW-1:0] cnt_x, exp_x, tol_x, diff;
   logic [3:0]    lock_n;

   sync_edge_detect #(
      .C_MIN_WIDTH(C_MIN_WIDTH)
   ) u_edge (
      .i_Clk_p   (i_Clk_p),
      .i_Rst_p   (i_Rst_p),
      .i_SyncRe_p(bus.i_SyncRe_p),
      .i_SyncFe_p(bus.i_SyncFe_p),
      .o_Edge_p  (edge_w),
      .o_Runt_p  (runt_w),
      .o_Phase_p (phase_w)
   );

   // Widened unsigned compare: threshold never wraps.
   always_comb begin
      acc     = edge_w && (state_q != ST_IDLE);
      cnt_x   = CW'(cnt_q);
      exp_x   = CW'(bus.iv16_ExpectedPeriod_p);
      tol_x   = CW'(bus.iv4_Tolerance_p);
      diff    = (cnt_x >= exp_x) ? cnt_x - exp_x : exp_x - cnt_x;
      good    = diff <= tol_x;
      lock_n  = (bus.iv4_LockCount_p == 4'd0) ? 4'd1
                                              : bus.iv4_LockCount_p;
      in_lock = state_q == ST_LOCKED;
      // An edge landing on the threshold is a bad edge, not a miss.
      miss    = in_lock && !acc && (cnt_x == exp_x + tol_x + CW'(1));
      // Flywheel strobe where the pulse was due.
      pred    = in_lock && !acc && (cnt_x == exp_x);
      lock_err = in_lock && ((acc && !good) || runt_w || miss);
   end

   always_comb begin
      state_d = state_q;
      good_d  = good_q;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.i_Enable_p) state_d = ST_SEARCH;
         end
         ST_SEARCH: begin
            if (acc) begin
               state_d = ST_ACQUIRE;
               good_d  = 4'd0;
            end
         end
         ST_ACQUIRE: begin
            if (runt_w || (acc && !good)) begin
               good_d = 4'd0;
            end else if (acc) begin
               if (good_q != 4'hF) good_d = good_q + 4'd1;
               if (good_d >= lock_n) state_d = ST_LOCKED;
            end
         end
         ST_LOCKED: begin
            if (lock_err) begin
               state_d = ST_ACQUIRE;
               good_d  = 4'd0;
            end
         end
      endcase
      if (!bus.i_Enable_p) state_d = ST_IDLE;
   end

   always_comb begin
      cnt_d = cnt_q;
      if (state_q == ST_IDLE) begin
         cnt_d = '0;
      end else if (acc) begin
         cnt_d = C_PERIOD_W'(1);
      end else if (!(&cnt_q)) begin
         cnt_d = cnt_q + C_PERIOD_W'(1);
      end
      // First edge in SEARCH has no preceding edge to measure from.
      meas_d   = (acc && state_q != ST_SEARCH) ? cnt_q : meas_q;
      phase_d  = acc ? phase_w : phase_q;
      strobe_d = acc || pred;
      err_d    = err_q;
      if (bus.i_ClearStats_p) begin
         err_d = '0;
      end else if (lock_err && !(&err_q)) begin
         err_d = err_q + C_PERIOD_W'(1);
      end
   end

   always_ff @(posedge i_Clk_p) begin
      if (i_Rst_p) begin
         state_q  <= ST_IDLE;
         good_q   <= 4'd0;
         cnt_q    <= '0;
         meas_q   <= '0;
         err_q    <= '0;
         phase_q  <= 1'b0;
         strobe_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         good_q   <= good_d;
         cnt_q    <= cnt_d;
         meas_q   <= meas_d;
         err_q    <= err_d;
         phase_q  <= phase_d;
         strobe_q <= strobe_d;
      end
   end

   // Reset kills a strobe already queued in the register.
   assign bus.o_SyncOut_p           = strobe_q && !i_Rst_p;
   assign bus.o_Locked_p            = state_q == ST_LOCKED;
   assign bus.ov16_MeasuredPeriod_p = meas_q;
   assign bus.ov16_ErrorCount_p     = err_q;
   assign bus.o_PhaseFe_p           = phase_q;
   assign bus.ov2_State_p           = state_q;
endmodule

// File: tb/tb_sync_pulse_receiver.sv
// Bench for sync_pulse_receiver: pulse table, strobe scoreboard,
// saturation/clear on a narrow instance, enable-off and reset cases.
module tb_sync_pulse_receiver;
   import sync_rx_pkg::*;

   typedef struct {
      int gap;
      int width;
      int pres;
      int fe;
      int pred;
      int st;
      int err;
      int meas;
      int ph;
   } rec_t;

   logic clk = 1'b0;
   logic rst;

   sync_rx_if #(.W(16)) bus ();
   sync_rx_if #(.W(4))  bus2 ();

   sync_pulse_receiver #(
      .C_MIN_WIDTH(2),
      .C_PERIOD_W (16)
   ) dut (
      .i_Clk_p(clk),
      .i_Rst_p(rst),
      .bus    (bus.slave)
   );

   sync_pulse_receiver #(
      .C_MIN_WIDTH(2),
      .C_PERIOD_W (4)
   ) dut2 (
      .i_Clk_p(clk),
      .i_Rst_p(rst),
      .bus    (bus2.slave)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int sbq[$];
   rec_t recs[$];
   int last_ref;
   int last_real;
   int last2;

   task automatic chk(input string nm, input int act, input int exp_v);
      total++;
      if (act != exp_v) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (cycle %0d)",
                  nm, act, exp_v, cyc);
      end
   endtask

   // Strobe scoreboard is checked every cycle at the falling edge.
   task automatic tick();
      @(negedge clk);
      if (bus.o_SyncOut_p) begin
         total++;
         if (sbq.size() == 0) begin
            bad++;
            $display("FAIL strobe: unexpected at cycle %0d", cyc);
         end else begin
            int e;
            e = sbq.pop_front();
            if (e != cyc) begin
               bad++;
               $display("FAIL strobe: got cycle %0d want %0d", cyc, e);
            end
         end
      end else if (sbq.size() > 0 && sbq[0] <= cyc) begin
         total++;
         bad++;
         $display("FAIL strobe: missing, got none want cycle %0d", sbq[0]);
         void'(sbq.pop_front());
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   function automatic rec_t mk(int gap, int width, int pres, int fe,
                               int pred, int st, int err, int meas,
                               int ph);
      rec_t r;
      r.gap = gap; r.width = width; r.pres = pres; r.fe = fe;
      r.pred = pred; r.st = st; r.err = err; r.meas = meas; r.ph = ph;
      return r;
   endfunction

   task automatic pulse2(input int gap, input bit clr);
      while (cyc < last2 + gap) tick();
      bus2.i_SyncRe_p     = 1'b1;
      bus2.i_ClearStats_p = clr;
      last2 = cyc;
      tick();
      bus2.i_ClearStats_p = 1'b0;
      tick();
      bus2.i_SyncRe_p = 1'b0;
   endtask

   initial begin
      rec_t r;
      // gap width pres fe pred | state err meas phase
      recs.push_back(mk( 10, 2, 1, 1, 0, 2, 0,   0, 1));
      recs.push_back(mk(100, 2, 1, 0, 0, 2, 0, 100, 0));
      recs.push_back(mk(100, 2, 1, 1, 0, 2, 0, 100, 1));
      recs.push_back(mk(100, 2, 1, 0, 0, 2, 0, 100, 0));
      recs.push_back(mk(100, 2, 1, 1, 0, 3, 0, 100, 1));
      recs.push_back(mk(100, 2, 1, 0, 0, 3, 0, 100, 0));
      recs.push_back(mk(100, 0, 0, 0, 1, 2, 1, 100, 0));
      recs.push_back(mk(100, 2, 1, 1, 0, 2, 1, 200, 1));
      recs.push_back(mk(100, 2, 1, 0, 0, 2, 1, 100, 0));
      recs.push_back(mk(100, 2, 1, 1, 0, 2, 1, 100, 1));
      recs.push_back(mk(100, 2, 1, 0, 0, 2, 1, 100, 0));
      recs.push_back(mk(100, 2, 1, 1, 0, 3, 1, 100, 1));
      recs.push_back(mk(100, 1, 1, 0, 0, 2, 2, 100, 0));
      recs.push_back(mk(100, 2, 1, 1, 0, 2, 2, 100, 1));
      recs.push_back(mk(100, 2, 1, 0, 0, 2, 2, 100, 0));
      recs.push_back(mk(100, 2, 1, 1, 0, 2, 2, 100, 1));
      recs.push_back(mk(100, 2, 1, 0, 0, 3, 2, 100, 0));
      recs.push_back(mk(102, 2, 1, 1, 1, 3, 2, 102, 1));
      recs.push_back(mk(103, 2, 1, 0, 1, 2, 3, 103, 0));
      recs.push_back(mk(100, 2, 1, 0, 0, 2, 3, 100, 0));
      recs.push_back(mk(100, 2, 1, 1, 0, 2, 3, 100, 1));
      recs.push_back(mk(100, 2, 1, 0, 0, 2, 3, 100, 0));
      recs.push_back(mk(100, 2, 1, 1, 0, 3, 3, 100, 1));

      rst = 1'b1;
      bus.i_SyncRe_p = 0; bus.i_SyncFe_p = 0;
      bus.i_Enable_p = 0; bus.i_ClearStats_p = 0;
      bus.iv16_ExpectedPeriod_p = 16'd100;
      bus.iv4_Tolerance_p = 4'd2;
      bus.iv4_LockCount_p = 4'd4;
      bus2.i_SyncRe_p = 0; bus2.i_SyncFe_p = 0;
      bus2.i_Enable_p = 0; bus2.i_ClearStats_p = 0;
      bus2.iv16_ExpectedPeriod_p = 16'd3;
      bus2.iv4_Tolerance_p = 4'd0;
      bus2.iv4_LockCount_p = 4'd0;
      repeat (3) tick();

      chk("rst_state", int'(bus.ov2_State_p), 0);
      chk("rst_locked", int'(bus.o_Locked_p), 0);
      chk("rst_meas", int'(bus.ov16_MeasuredPeriod_p), 0);
      chk("rst_err", int'(bus.ov16_ErrorCount_p), 0);
      chk("rst_phase", int'(bus.o_PhaseFe_p), 0);
      chk("rst_strobe", int'(bus.o_SyncOut_p), 0);

      rst = 1'b0;
      bus.i_Enable_p = 1'b1;
      tick();
      tick();
      chk("search", int'(bus.ov2_State_p), 1);

      last_ref  = cyc;
      last_real = cyc;
      for (int i = 0; i < recs.size(); i++) begin
         r = recs[i];
         if (r.pred != 0) sbq.push_back(last_real + 101);
         while (cyc < last_ref + r.gap - 1) tick();
         bus.i_SyncFe_p = r.fe[0];
         tick();
         bus.i_SyncFe_p = 1'b0;
         last_ref = cyc;
         if (r.pres != 0) begin
            bus.i_SyncRe_p = 1'b1;
            sbq.push_back(cyc + 1);
            last_real = cyc;
         end
         repeat (r.width) tick();
         bus.i_SyncRe_p = 1'b0;
         while (cyc < last_ref + 6) tick();
         chk($sformatf("rec%0d_state", i), int'(bus.ov2_State_p), r.st);
         chk($sformatf("rec%0d_locked", i), int'(bus.o_Locked_p),
             (r.st == 3) ? 1 : 0);
         chk($sformatf("rec%0d_err", i),
             int'(bus.ov16_ErrorCount_p), r.err);
         chk($sformatf("rec%0d_meas", i),
             int'(bus.ov16_MeasuredPeriod_p), r.meas);
         chk($sformatf("rec%0d_phase", i), int'(bus.o_PhaseFe_p), r.ph);
      end

      bus.i_Enable_p = 1'b0;
      tick();
      chk("dis_state", int'(bus.ov2_State_p), 0);
      chk("dis_locked", int'(bus.o_Locked_p), 0);
      chk("dis_err", int'(bus.ov16_ErrorCount_p), 3);
      chk("dis_meas", int'(bus.ov16_MeasuredPeriod_p), 100);
      chk("dis_phase", int'(bus.o_PhaseFe_p), 1);

      bus2.i_Enable_p = 1'b1;
      tick();
      tick();
      last2 = cyc;
      pulse2(3, 1'b0);
      chk("n_acq", int'(bus2.ov2_State_p), 2);
      pulse2(3, 1'b0);
      chk("n_lock_lc0", int'(bus2.ov2_State_p), 3);
      for (int i = 1; i <= 20; i++) begin
         pulse2(4, 1'b0);
         chk($sformatf("n_err%0d", i), int'(bus2.ov16_ErrorCount_p),
             (i < 15) ? i : 15);
         chk($sformatf("n_st%0d", i), int'(bus2.ov2_State_p), 2);
         pulse2(3, 1'b0);
      end
      chk("n_meas", int'(bus2.ov16_MeasuredPeriod_p), 3);
      pulse2(4, 1'b1);
      chk("n_clr_win", int'(bus2.ov16_ErrorCount_p), 0);
      pulse2(3, 1'b0);
      pulse2(4, 1'b0);
      chk("n_after_clr", int'(bus2.ov16_ErrorCount_p), 1);
      bus2.i_Enable_p = 1'b0;

      bus.i_Enable_p = 1'b1;
      tick();
      tick();
      bus.i_SyncRe_p = 1'b1;
      tick();
      rst = 1'b1;
      bus.i_SyncRe_p = 1'b0;
      tick();
      chk("mr_state", int'(bus.ov2_State_p), 0);
      chk("mr_locked", int'(bus.o_Locked_p), 0);
      chk("mr_meas", int'(bus.ov16_MeasuredPeriod_p), 0);
      chk("mr_err", int'(bus.ov16_ErrorCount_p), 0);
      chk("mr_phase", int'(bus.o_PhaseFe_p), 0);
      chk("mr_strobe", int'(bus.o_SyncOut_p), 0);
      chk("mr_err2", int'(bus2.ov16_ErrorCount_p), 0);
      rst = 1'b0;
      bus.i_Enable_p = 1'b0;
      repeat (4) tick();
      chk("sb_left", sbq.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
